// File: rtl/btb_pkg.sv
// Shared types and constants for the branch target buffer update path.
package btb_pkg;

    localparam int IDX_W = 7;
    localparam int PC_W  = 30;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] tag;
        logic [PC_W-1:0] target;
        logic [1:0]      ctr;
    } btb_entry_t;

    typedef enum logic [1:0] {
        ST_START,
        ST_CLEAR,
        ST_RUN
    } btb_state_e;

    function automatic logic [1:0] ctr_next(input logic [1:0] c,
                                            input logic       taken);
        if (taken)
            return (c == CTR_ST) ? CTR_ST : c + 2'd1;
        return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Two-push / one-pop update queue; lane a lands ahead of lane b.
module btb_upd_fifo #(
    parameter int DW    = 61,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          clear,
    input  logic          push_a,
    input  logic [DW-1:0] data_a,
    input  logic          push_b,
    input  logic [DW-1:0] data_b,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          empty,
    output logic [CW-1:0] free
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr_b;
    logic [CW-1:0] count;
    logic [CW-1:0] n_push;

    assign n_push = CW'(push_a) + CW'(push_b);
    assign wptr_b = push_a ? wptr + 1'b1 : wptr;
    assign head   = mem[rptr];
    assign empty  = (count == '0);
    assign free   = CW'(DEPTH) - count;

    always_ff @(posedge CLK) begin
        if (push_a)
            mem[wptr] <= data_a;
        if (push_b)
            mem[wptr_b] <= data_b;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(n_push);
            rptr  <= rptr + AW'(pop);
            count <= count + n_push - CW'(pop);
        end
    end

endmodule

// File: rtl/btb_update_arbiter.sv
// Merges lane a/b branch updates onto the predictor RMW port and clears the table.
// Optional stats counters: define BTB_ARB_STATS_EN.
module btb_update_arbiter #(
    parameter int IDX_W  = btb_pkg::IDX_W,
    parameter int PC_W   = btb_pkg::PC_W,
    parameter int QDEPTH = 4,
    localparam int EW    = 2 * PC_W + 3,
    localparam int FW    = 2 * PC_W + 1,
    localparam int CW    = $clog2(QDEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             a_upd_valid,
    input  logic [PC_W-1:0]  a_upd_pc,
    input  logic [PC_W-1:0]  a_upd_target,
    input  logic             a_upd_taken,
    input  logic             b_upd_valid,
    input  logic [PC_W-1:0]  b_upd_pc,
    input  logic [PC_W-1:0]  b_upd_target,
    input  logic             b_upd_taken,
    output logic             upd_ready,
    input  logic             flush_req,
    output logic             busy,
    output logic [IDX_W-1:0] rd_idx,
    input  logic [EW-1:0]    rd_entry,
    output logic             wr_en,
    output logic [IDX_W-1:0] wr_idx,
    output logic [EW-1:0]    wr_entry,
    output logic [15:0]      alloc_cnt,
    output logic [15:0]      hit_cnt
);

    import btb_pkg::*;

    btb_state_e       state;
    logic [IDX_W-1:0] clr_idx;
    logic             run;
    logic             clearing;
    logic             push_a;
    logic             push_b;
    logic             pop;
    logic             fifo_clr;
    logic             empty;
    logic [CW-1:0]    free;
    logic [FW-1:0]    head;
    logic [PC_W-1:0]  h_pc;
    logic [PC_W-1:0]  h_tgt;
    logic             h_tk;
    logic             hit;
    btb_entry_t       cur;
    btb_entry_t       nxt;

    assign run       = (state == ST_RUN);
    assign clearing  = (state == ST_CLEAR);
    assign busy      = ~run;
    assign upd_ready = run && (free >= CW'(2));

    // Pushes racing a flush are dropped along with the queue contents.
    assign push_a   = a_upd_valid & upd_ready & ~flush_req;
    assign push_b   = b_upd_valid & upd_ready & ~flush_req;
    assign fifo_clr = run & flush_req;
    assign pop      = run & ~flush_req & ~empty;

    btb_upd_fifo #(
        .DW    (FW),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (fifo_clr),
        .push_a (push_a),
        .data_a ({a_upd_pc, a_upd_target, a_upd_taken}),
        .push_b (push_b),
        .data_b ({b_upd_pc, b_upd_target, b_upd_taken}),
        .pop    (pop),
        .head   (head),
        .empty  (empty),
        .free   (free)
    );

    assign h_pc  = head[FW-1 -: PC_W];
    assign h_tgt = head[PC_W:1];
    assign h_tk  = head[0];

    assign cur = rd_entry;
    assign hit = cur.valid && (cur.tag == h_pc);

    always_comb begin
        nxt       = '0;
        nxt.valid = 1'b1;
        if (hit) begin
            nxt.tag    = cur.tag;
            nxt.target = h_tk ? h_tgt : cur.target;
            nxt.ctr    = ctr_next(cur.ctr, h_tk);
        end else begin
            nxt.tag    = h_pc;
            nxt.target = h_tgt;
            nxt.ctr    = h_tk ? CTR_WT : CTR_WNT;
        end
    end

    always_comb begin
        wr_en    = 1'b0;
        rd_idx   = '0;
        wr_entry = '0;
        unique case (1'b1)
            clearing: begin
                wr_en  = 1'b1;
                rd_idx = clr_idx;
            end
            pop: begin
                wr_en    = 1'b1;
                rd_idx   = h_pc[IDX_W-1:0];
                wr_entry = nxt;
            end
            default: ;
        endcase
    end

    assign wr_idx = rd_idx;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= ST_START;
            clr_idx <= '0;
        end else begin
            case (state)
                ST_START: begin
                    state   <= ST_CLEAR;
                    clr_idx <= '0;
                end
                ST_CLEAR: begin
                    if (flush_req)
                        clr_idx <= '0;
                    else begin
                        clr_idx <= clr_idx + 1'b1;
                        if (clr_idx == '1)
                            state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (flush_req) begin
                        state   <= ST_CLEAR;
                        clr_idx <= '0;
                    end
                end
                default: state <= ST_START;
            endcase
        end
    end

`ifdef BTB_ARB_STATS_EN
    logic [15:0] alloc_q;
    logic [15:0] hit_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            alloc_q <= '0;
            hit_q   <= '0;
        end else if (pop) begin
            if (hit && hit_q != 16'hFFFF)
                hit_q <= hit_q + 16'd1;
            if (!hit && alloc_q != 16'hFFFF)
                alloc_q <= alloc_q + 16'd1;
        end
    end

    assign alloc_cnt = alloc_q;
    assign hit_cnt   = hit_q;
`else
    assign alloc_cnt = '0;
    assign hit_cnt   = '0;
`endif

endmodule

// File: tb/tb_btb_update_arbiter.sv
// Randomised bench for btb_update_arbiter against a queue/array reference model.
module tb_btb_update_arbiter;

    localparam int IW = 7;
    localparam int PW = 30;
    localparam int EW = 2 * PW + 3;
    localparam int QD = 4;
    localparam int NE = 128;
    localparam int VW = 3 + 2 * IW + EW;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          a_upd_valid = 1'b0;
    logic [PW-1:0] a_upd_pc = '0;
    logic [PW-1:0] a_upd_target = '0;
    logic          a_upd_taken = 1'b0;
    logic          b_upd_valid = 1'b0;
    logic [PW-1:0] b_upd_pc = '0;
    logic [PW-1:0] b_upd_target = '0;
    logic          b_upd_taken = 1'b0;
    logic          flush_req = 1'b0;
    logic          upd_ready;
    logic          busy;
    logic [IW-1:0] rd_idx;
    logic [EW-1:0] rd_entry;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [EW-1:0] wr_entry;
    logic [15:0]   alloc_cnt;
    logic [15:0]   hit_cnt;

    btb_update_arbiter #(.IDX_W(IW), .PC_W(PW), .QDEPTH(QD)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .a_upd_valid  (a_upd_valid),
        .a_upd_pc     (a_upd_pc),
        .a_upd_target (a_upd_target),
        .a_upd_taken  (a_upd_taken),
        .b_upd_valid  (b_upd_valid),
        .b_upd_pc     (b_upd_pc),
        .b_upd_target (b_upd_target),
        .b_upd_taken  (b_upd_taken),
        .upd_ready    (upd_ready),
        .flush_req    (flush_req),
        .busy         (busy),
        .rd_idx       (rd_idx),
        .rd_entry     (rd_entry),
        .wr_en        (wr_en),
        .wr_idx       (wr_idx),
        .wr_entry     (wr_entry),
        .alloc_cnt    (alloc_cnt),
        .hit_cnt      (hit_cnt)
    );

    always #5 CLK = ~CLK;

    // Table storage driven only by the DUT's write port.
    logic [EW-1:0] tab [NE];
    assign rd_entry = tab[rd_idx];
    always @(posedge CLK) if (wr_en) tab[wr_idx] <= wr_entry;

    typedef struct {
        logic [PW-1:0] pc;
        logic [PW-1:0] tgt;
        logic          tk;
    } upd_t;

    upd_t          q[$];
    logic [EW-1:0] mtab [NE];
    int            cpos;
    int            m_alloc;
    int            m_hit;
    int            errors = 0;
    int            checks = 0;
    int            accepted;
    logic          e_rdy;
    logic          e_we;
    logic [IW-1:0] e_idx;
    logic [EW-1:0] e_ent;
    logic [VW-1:0] exp_v;

    function automatic logic [EW-1:0] mk(input logic v, input logic [PW-1:0] tag,
                                         input logic [PW-1:0] tgt, input logic [1:0] c);
        return {v, tag, tgt, c};
    endfunction

    function automatic logic is_hit(input logic [EW-1:0] e, input upd_t u);
        return e[EW-1] && (e[EW-2 -: PW] == u.pc);
    endfunction

    function automatic logic [EW-1:0] rmw(input logic [EW-1:0] e, input upd_t u);
        int c;
        logic [PW-1:0] tg;
        if (!is_hit(e, u))
            return mk(1'b1, u.pc, u.tgt, u.tk ? 2'd2 : 2'd1);
        c  = int'(e[1:0]);
        tg = e[PW+1:2];
        if (u.tk) begin
            c  = (c == 3) ? 3 : c + 1;
            tg = u.tgt;
        end else begin
            c = (c == 0) ? 0 : c - 1;
        end
        return mk(1'b1, u.pc, tg, 2'(c));
    endfunction

    function automatic logic [VW-1:0] obs();
        return {busy, upd_ready, wr_en, wr_en ? {rd_idx, wr_idx, wr_entry} : {(2*IW+EW){1'b0}}};
    endfunction

    function automatic upd_t mku(input logic [PW-1:0] pc, input logic [PW-1:0] tgt,
                                 input logic tk);
        upd_t u;
        u.pc = pc;
        u.tgt = tgt;
        u.tk = tk;
        return u;
    endfunction

    // Drive one cycle of stimulus, form expectations, then wait to the sample point.
    task automatic tick(input logic av, input upd_t ua, input logic bv, input upd_t ub,
                        input logic fl);
        a_upd_valid = av;  a_upd_pc = ua.pc;  a_upd_target = ua.tgt;  a_upd_taken = ua.tk;
        b_upd_valid = bv;  b_upd_pc = ub.pc;  b_upd_target = ub.tgt;  b_upd_taken = ub.tk;
        flush_req = fl;
        e_rdy = (cpos == NE) && (QD - q.size() >= 2);
        e_we  = 1'b0;
        e_idx = '0;
        e_ent = '0;
        if (cpos >= 0 && cpos < NE) begin
            e_we  = 1'b1;
            e_idx = IW'(cpos);
        end else if (cpos == NE && !fl && q.size() > 0) begin
            e_we  = 1'b1;
            e_idx = q[0].pc[IW-1:0];
            e_ent = rmw(mtab[e_idx], q[0]);
        end
        exp_v = {cpos < NE, e_rdy, e_we, e_we ? {e_idx, e_idx, e_ent} : {(2*IW+EW){1'b0}}};
        @(negedge CLK);
    endtask

    // Take the clock edge and advance the reference model.
    task automatic adv();
        upd_t u;
        @(posedge CLK);
        if (cpos < 0) begin
            cpos = 0;
        end else if (cpos < NE) begin
            mtab[cpos] = '0;
            cpos = flush_req ? 0 : cpos + 1;
        end else if (flush_req) begin
            q.delete();
            cpos = 0;
        end else begin
            if (q.size() > 0) begin
                u = q.pop_front();
                if (is_hit(mtab[u.pc[IW-1:0]], u)) m_hit = (m_hit < 65535) ? m_hit + 1 : m_hit;
                else m_alloc = (m_alloc < 65535) ? m_alloc + 1 : m_alloc;
                mtab[u.pc[IW-1:0]] = rmw(mtab[u.pc[IW-1:0]], u);
            end
            if (e_rdy && a_upd_valid) begin q.push_back(mku(a_upd_pc, a_upd_target, a_upd_taken)); accepted++; end
            if (e_rdy && b_upd_valid) begin q.push_back(mku(b_upd_pc, b_upd_target, b_upd_taken)); accepted++; end
        end
        #1;
    endtask

    function automatic upd_t rnd_upd();
        return mku(30'($urandom_range(0, 3) * 128 + $urandom_range(0, 7)),
                   30'($urandom), 1'($urandom));
    endfunction

    task automatic test_reset();
        upd_t z;
        z = mku('0, '0, 1'b0);
        RST = 1'b0;
        q.delete();
        cpos = -1;
        m_alloc = 0;
        m_hit = 0;
        #2;
        checks++;
        if ({busy, upd_ready, wr_en, alloc_cnt, hit_cnt} !== {3'b100, 32'd0}) begin
            errors++;
            $display("FAIL reset_vals got=%b/%b/%b/%h/%h exp=1/0/0/0/0",
                     busy, upd_ready, wr_en, alloc_cnt, hit_cnt);
        end
        @(posedge CLK);
        #1;
        RST = 1'b1;
        for (int i = 0; i < NE + 2; i++) begin
            tick(1'b0, z, 1'b0, z, 1'b0);
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL clear_seq cyc=%0d got=%h exp=%h", i, obs(), exp_v);
            end
            adv();
        end
    endtask

    task automatic test_alloc();
        upd_t z;
        z = mku('0, '0, 1'b0);
        tick(1'b1, mku(30'h10, 30'h40, 1'b1), 1'b0, z, 1'b0);
        adv();
        tick(1'b0, z, 1'b0, z, 1'b0);
        checks++;
        if (obs() !== exp_v || wr_entry !== mk(1'b1, 30'h10, 30'h40, 2'b10)) begin
            errors++;
            $display("FAIL alloc got=%h exp=%h", obs(), exp_v);
        end
        adv();
    endtask

    task automatic test_counter();
        logic [1:0] seq [9] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
        upd_t z;
        int   n;
        z = mku('0, '0, 1'b0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick(i < 9, mku(30'h10, 30'h40 + 30'(i), i < 4), 1'b0, z, 1'b0);
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL counter_model cyc=%0d got=%h exp=%h", i, obs(), exp_v);
            end
            if (wr_en && n < 9) begin
                checks++;
                if (wr_entry[1:0] !== seq[n]) begin
                    errors++;
                    $display("FAIL counter_seq n=%0d got=%b exp=%b", n, wr_entry[1:0], seq[n]);
                end
                n++;
            end
            adv();
        end
        checks++;
        if (n != 9) begin
            errors++;
            $display("FAIL counter_writes got=%0d exp=9", n);
        end
    endtask

    task automatic test_dual();
        upd_t z;
        logic [EW-1:0] want [2];
        z = mku('0, '0, 1'b0);
        want[0] = mk(1'b1, 30'h25, 30'h111, 2'b10);
        want[1] = mk(1'b1, 30'hA5, 30'h222, 2'b01);
        tick(1'b1, mku(30'h25, 30'h111, 1'b1), 1'b1, mku(30'hA5, 30'h222, 1'b0), 1'b0);
        adv();
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, z, 1'b0, z, 1'b0);
            checks++;
            if (obs() !== exp_v || wr_idx !== 7'h25 || wr_entry !== want[i]) begin
                errors++;
                $display("FAIL dual_order n=%0d got=%h exp=%h", i, obs(), exp_v);
            end
            adv();
        end
    endtask

    task automatic test_back_to_back();
        upd_t z;
        int   writes;
        z = mku('0, '0, 1'b0);
        writes = 0;
        accepted = 0;
        for (int i = 0; i < 16; i++) begin
            tick(i < 10, rnd_upd(), i < 10, rnd_upd(), 1'b0);
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL b2b cyc=%0d got=%h exp=%h", i, obs(), exp_v);
            end
            if (wr_en) writes++;
            adv();
        end
        checks++;
        if (writes != accepted || q.size() != 0) begin
            errors++;
            $display("FAIL b2b_no_loss got=%0d exp=%0d", writes, accepted);
        end
    endtask

    task automatic test_flush();
        upd_t z;
        z = mku('0, '0, 1'b0);
        tick(1'b1, mku(30'h30, 30'h1, 1'b1), 1'b1, mku(30'h31, 30'h2, 1'b1), 1'b0);
        adv();
        tick(1'b1, mku(30'h32, 30'h3, 1'b0), 1'b1, mku(30'h33, 30'h4, 1'b1), 1'b0);
        adv();
        tick(1'b1, mku(30'h34, 30'h5, 1'b1), 1'b0, z, 1'b1);
        checks++;
        if (obs() !== exp_v || q.size() != 3) begin
            errors++;
            $display("FAIL flush_cycle got=%h exp=%h", obs(), exp_v);
        end
        adv();
        for (int i = 0; i < NE + 12; i++) begin
            tick(1'b1, rnd_upd(), 1'b0, z, i == 5);
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL flush_clear cyc=%0d got=%h exp=%h", i, obs(), exp_v);
            end
            adv();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom), rnd_upd(), 1'($urandom), rnd_upd(), $urandom_range(0, 199) == 0);
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, obs(), exp_v);
            end
            adv();
        end
    endtask

    task automatic test_stats();
        int ea;
        int eh;
`ifdef BTB_ARB_STATS_EN
        ea = m_alloc;
        eh = m_hit;
`else
        ea = 0;
        eh = 0;
`endif
        checks++;
        if (alloc_cnt !== 16'(ea) || hit_cnt !== 16'(eh)) begin
            errors++;
            $display("FAIL stats got=%0d/%0d exp=%0d/%0d", alloc_cnt, hit_cnt, ea, eh);
        end
    endtask

    task automatic test_rst_midrun();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, rnd_upd(), 1'b1, rnd_upd(), 1'b0);
            adv();
        end
        a_upd_valid = 1'b0;
        b_upd_valid = 1'b0;
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if ({busy, upd_ready, wr_en, alloc_cnt, hit_cnt} !== {3'b100, 32'd0}) begin
            errors++;
            $display("FAIL rst_midrun got=%b/%b/%b/%h/%h exp=1/0/0/0/0",
                     busy, upd_ready, wr_en, alloc_cnt, hit_cnt);
        end
        test_reset();
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_counter();
        test_dual();
        test_stats();
        test_back_to_back();
        test_flush();
        test_random();
        test_stats();
        test_rst_midrun();
        test_alloc();
        test_stats();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
